bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (one bit per clock).
- Sits directly upstream of the 4-digit seven-segment multiplexer and drives its D/C/B/A digit inputs, e.g. for the game score or round display.
- Holds the last converted digits stable between conversions, so the display never shows partial results.
- Start/busy/done handshake with the game control logic.

Parameters:
- WIDTH, 14, width of the binary input; legal range 4..14; full-scale 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge
- D  output  4  thousands digit (BCD)
- C  output  4  hundreds digit (BCD)
- B  output  4  tens digit (BCD)
- A  output  4  ones digit (BCD)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: new digits valid
- overflow  output  1  last conversion saturated; sticky until the next accepted start

Behaviour:
- Reset, on any edge with reset=1, overriding everything:
  - D=C=B=A=0; busy=0; done=0; overflow=0; state=IDLE; internal shift/BCD registers cleared.
  - A reset mid-conversion aborts it; no done pulse is produced.
- States:
  - IDLE: busy=0. If start=1, latch bin into the shift register, clear the 16-bit BCD scratch, load bit counter=WIDTH, clear overflow, go to CONV.
  - CONV: busy=1. Each cycle, first add 3 to every scratch nibble >=5, then shift {scratch, shift_reg} left by 1 and decrement the counter. After the WIDTH-th shift, go to FINISH.
  - FINISH: busy=1. Load D/C/B/A from the scratch nibbles [15:12]/[11:8]/[7:4]/[3:0], pulse done, go to IDLE.
- Timing: if start is accepted at edge k, shifts occur at edges k+1..k+WIDTH and outputs update at edge k+WIDTH+1.
  - done=1 for exactly the cycle following edge k+WIDTH+1.
  - busy=1 from edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
- Back-to-back operation: start asserted during the done cycle (state IDLE) is accepted. No dead cycle is required.
- start while busy is ignored; it is not queued, and the latched bin is unaffected.
- bin changing after acceptance has no effect on the conversion in flight.
- Saturation:
  - If the captured bin > 9999, FINISH loads D=C=B=A=9 and sets overflow=1 together with done.
  - The comparison is made on the captured value at accept time; the shift engine may run normally and its result is discarded.
  - Only applies when 2^WIDTH-1 > 9999.
- D/C/B/A hold their previous values throughout CONV and FINISH until the update edge. Digits are always legal BCD (0..9).
- Arithmetic: add-3 is applied per nibble on the 4-bit value with no carry between nibbles. The scratch register is 16 bits.

Test Plan:
- Reset, then start with bin=0 → busy high for 15 cycles (WIDTH=14); done pulses once 15 edges after the accept edge; D,C,B,A=0,0,0,0; overflow=0.
- bin=1234 → D,C,B,A=1,2,3,4. Then bin=9999 back-to-back (start held in the done cycle) → 9,9,9,9, overflow=0, second done exactly 15 cycles after the first.
- bin=10000, then bin=16383 → D,C,B,A=9,9,9,9, overflow=1. Then bin=42 → 0,0,4,2, overflow cleared at accept.
- Convert bin=0057 (→0,0,5,7); 3 cycles into CONV pulse start with bin=8888 and change bin → ignored; result 0,0,5,7; exactly one done pulse.
- After outputs show 5,6,7,8, start bin=4321; assert reset 5 cycles into CONV → next edge: all digits 0, busy=0; no done follows; a new start with bin=4321 then yields 4,3,2,1.
- Outputs hold: after 1,2,3,4, start bin=9876 → D,C,B,A read 1,2,3,4 on every cycle until the update edge, then 9,8,7,6.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (double-dabble, one bit per clock)
//           feeding the D/C/B/A digit inputs of the 4-digit seven-segment mux.
// Latency : start accepted at edge k -> digits and done update at edge k+WIDTH+1.
// Backpr. : start is honoured only in IDLE (busy=0); start while busy is dropped,
//           not queued. A start during the done cycle is accepted (no dead cycle).
//
// Ports:
//   clk      rising-edge system clock
//   reset    synchronous, active-high; aborts any conversion, clears all state
//   start    conversion request, sampled only while idle
//   bin      WIDTH-bit unsigned value, captured on the accepted start edge
//   D,C,B,A  thousands/hundreds/tens/ones BCD digits, held between conversions
//   busy     high while a conversion is in progress (WIDTH+1 cycles)
//   done     one-cycle pulse marking new digits
//   overflow last conversion saturated to 9999; cleared by the next accepted start

module bin2bcd_seq #(
  parameter int WIDTH = 14  // legal range 4..14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [3:0]       D,
  output logic [3:0]       C,
  output logic [3:0]       B,
  output logic [3:0]       A,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam int unsigned MAX_BCD = 9999;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] shift_q,   shift_d;    // binary bits still to be shifted in
  logic [15:0]      scratch_q, scratch_d;  // BCD accumulator being built
  logic [CNT_W-1:0] cnt_q,     cnt_d;      // shifts remaining
  logic             sat_q,     sat_d;      // captured value exceeds 9999
  logic [15:0]      dig_q,     dig_d;      // displayed digits {D,C,B,A}
  logic             done_q,    done_d;
  logic             ovf_q,     ovf_d;

  logic [15:0]      adj;                   // scratch after the per-nibble add-3
  logic             bin_over;
  logic             accept;

  // Saturation is decided on the value at accept time; for narrow WIDTH the
  // comparison is simply never true.
  assign bin_over = (32'(bin) > 32'(MAX_BCD));
  assign accept   = (state_q == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // State register (and all other flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      dig_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      dig_q     <= dig_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // cnt_q==1 means this cycle performs the final shift.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Add-3 correction: each nibble on its own 4-bit value, no inter-nibble carry.
  // ---------------------------------------------------------------------------
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    dig_d     = dig_q;   // digits hold until the FINISH edge
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          sat_d     = bin_over;
          ovf_d     = 1'b0;
        end
      end
      S_CONV: begin
        // Shift {scratch, shift} left by one after the correction.
        scratch_d = {adj[14:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
      end
      S_FINISH: begin
        // A saturated conversion discards the shift engine result.
        dig_d  = sat_q ? 16'h9999 : scratch_q;
        ovf_d  = sat_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    D        = dig_q[15:12];
    C        = dig_q[11:8];
    B        = dig_q[7:4];
    A        = dig_q[3:0];
    done     = done_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic [3:0]  D, C, B, A;
  logic        busy, done, overflow;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .D        (D),
    .C        (C),
    .B        (B),
    .A        (A),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {D, C, B, A};
  endfunction

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and wait (bounded) until done is observed.
  // lat: edges from the accept edge to the done edge.
  // busy_cnt: samples with busy=1 from the accept edge up to the done edge.
  task automatic do_conv(input logic [13:0] v, output int lat, output int busy_cnt,
                         output bit timeout, output bit ovf_at_accept);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    ovf_at_accept = overflow;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({digits(), busy, done, overflow} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state got digits=%h busy=%b done=%b ovf=%b want 0000/0/0/0",
               digits(), busy, done, overflow);
    end
  endtask

  task automatic test_zero();
    int lat, bc; bit to, oa;
    do_conv(14'd0, lat, bc, to, oa);
    checks++;
    if (to) begin errors++; $display("FAIL zero_timeout no done within bound"); end
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL zero_latency got %0d want 15", lat); end
    checks++;
    if (bc !== 15) begin errors++; $display("FAIL zero_busy_cycles got %0d want 15", bc); end
    checks++;
    if ({digits(), overflow} !== 17'h0) begin
      errors++;
      $display("FAIL zero_result got %h ovf=%b want 0000 ovf=0", digits(), overflow);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit to, oa;
    do_conv(14'd1234, lat, bc, to, oa);
    checks++;
    if (to || digits() !== 16'h1234) begin
      errors++;
      $display("FAIL b2b_first got %h timeout=%b want 1234", digits(), to);
    end
    // Still in the done cycle: the next start goes in with no dead cycle.
    do_conv(14'd9999, lat, bc, to, oa);
    checks++;
    if (to || lat !== 15) begin
      errors++;
      $display("FAIL b2b_latency got %0d timeout=%b want 15", lat, to);
    end
    checks++;
    if (bc !== 15) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 15", bc); end
    checks++;
    if ({digits(), overflow} !== {16'h9999, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got %h ovf=%b want 9999 ovf=0", digits(), overflow);
    end
  endtask

  task automatic test_saturation();
    int lat, bc; bit to, oa;
    logic [13:0] vin [2];
    vin[0] = 14'd10000;
    vin[1] = 14'd16383;
    tick();
    for (int i = 0; i < 2; i++) begin
      do_conv(vin[i], lat, bc, to, oa);
      checks++;
      if (to || {digits(), overflow} !== {16'h9999, 1'b1}) begin
        errors++;
        $display("FAIL sat_%0d got %h ovf=%b timeout=%b want 9999 ovf=1",
                 vin[i], digits(), overflow, to);
      end
    end
    do_conv(14'd42, lat, bc, to, oa);
    checks++;
    if (oa !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_at_accept got %b want 0", oa);
    end
    checks++;
    if (to || {digits(), overflow} !== {16'h0042, 1'b0}) begin
      errors++;
      $display("FAIL after_sat_42 got %h ovf=%b want 0042 ovf=0", digits(), overflow);
    end
  endtask

  task automatic test_vectors();
    int lat, bc; bit to, oa;
    logic [13:0] vin  [8];
    logic [15:0] vexp [8];
    vin[0] = 14'd9;    vexp[0] = 16'h0009;
    vin[1] = 14'd10;   vexp[1] = 16'h0010;
    vin[2] = 14'd99;   vexp[2] = 16'h0099;
    vin[3] = 14'd100;  vexp[3] = 16'h0100;
    vin[4] = 14'd999;  vexp[4] = 16'h0999;
    vin[5] = 14'd1000; vexp[5] = 16'h1000;
    vin[6] = 14'd5005; vexp[6] = 16'h5005;
    vin[7] = 14'd8191; vexp[7] = 16'h8191;
    for (int i = 0; i < 8; i++) begin
      tick();
      do_conv(vin[i], lat, bc, to, oa);
      checks++;
      if (to || digits() !== vexp[i] || overflow !== 1'b0) begin
        errors++;
        $display("FAIL vec_%0d got %h ovf=%b timeout=%b want %h ovf=0",
                 vin[i], digits(), overflow, to, vexp[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, dones;
    bit seen;
    tick();
    bin   = 14'd57;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bin   = 14'd8888;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 14'd1111;
    lat   = 4;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      lat++;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || lat !== 15) begin
      errors++;
      $display("FAIL ignore_latency got %0d seen=%b want 15", lat, seen);
    end
    checks++;
    if (digits() !== 16'h0057) begin
      errors++;
      $display("FAIL ignore_result got %h want 0057", digits());
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_extra_done got %0d busy=%b want 0 busy=0", dones, busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones; bit to, oa;
    do_conv(14'd5678, lat, bc, to, oa);
    checks++;
    if (to || digits() !== 16'h5678) begin
      errors++;
      $display("FAIL abort_pre got %h want 5678", digits());
    end
    tick();
    bin   = 14'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({digits(), busy, done, overflow} !== 19'h0) begin
      errors++;
      $display("FAIL abort_state got %h busy=%b done=%b ovf=%b want 0000/0/0/0",
               digits(), busy, done, overflow);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", dones);
    end
    do_conv(14'd4321, lat, bc, to, oa);
    checks++;
    if (to || digits() !== 16'h4321) begin
      errors++;
      $display("FAIL abort_restart got %h want 4321", digits());
    end
  endtask

  task automatic test_hold();
    int lat, bc; bit to, oa, seen;
    tick();
    do_conv(14'd1234, lat, bc, to, oa);
    tick();
    bin   = 14'd9876;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      checks++;
      if (digits() !== 16'h1234) begin
        errors++;
        $display("FAIL hold_cycle_%0d got %h want 1234", i, digits());
      end
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || digits() !== 16'h9876) begin
      errors++;
      $display("FAIL hold_update got %h seen=%b want 9876", digits(), seen);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_saturation();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
